timer_cnt_core: RTL and testbench
=================================

Name: timer_cnt_core

Overview:
- Counting engine of the 8-bit timer. Sits directly downstream of the timer register file.
- Consumes the TCR fields (enable, load, direction, clock select) and the TDR value from the register file.
- Produces the live TCNT value plus single-cycle overflow and underflow events. The register file turns these events into sticky TSR bits and the interrupt.
- Contains a prescaler (÷1/÷2/÷4/÷8), load logic, up/down counting and pause.

Parameters:
- CNT_W, 8, counter width (TCNT/TDR width)
- PSC_W, 3, prescaler counter width; must be at least log2 of the largest division ratio (8)

Ports:
- clk  input  1  timer clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- en  input  1  TCR.EN: 1 = count, 0 = pause (hold)
- load  input  1  single-cycle pulse: copy tdr into TCNT
- tdr  input  CNT_W  TDR value used by load
- up_dn  input  1  TCR.UP_DN: 0 = count up, 1 = count down
- cks  input  2  TCR.CKS: 00 ÷1, 01 ÷2, 10 ÷4, 11 ÷8
- tcnt  output  CNT_W  current counter value (TCNT read data)
- tick  output  1  qualified count strobe, combinational from prescaler state (debug and coverage)
- ovf  output  1  registered 1-cycle pulse: up-count wrapped from max to 0
- udf  output  1  registered 1-cycle pulse: down-count wrapped from 0 to max

Behaviour:
- Reset (rst_n=0, asynchronous):
  - tcnt=0x00, ovf=0, udf=0, prescaler counter psc=0.
  - Takes effect immediately, including mid-count. Counting resumes per the rules below after release.
- Prescaler:
  - psc increments by 1 every cycle en=1 and wraps modulo 2^PSC_W.
  - psc clears to 0 on any cycle en=0 and on any cycle load=1.
- Tick:
  - mask = 0/1/3/7 for cks = 00/01/10/11.
  - tick = en & ~load & ((psc & mask) == mask).
  - After en rises with psc=0, the first tick occurs in the N-th enabled cycle (N = 1/2/4/8). Subsequent ticks follow every N cycles.
- cks change while counting: no reset of psc. The new mask applies from the next cycle. One shortened or lengthened period is allowed; no spurious double tick in a single cycle.
- Counter update (priority highest first):
  1. load=1: tcnt<=tdr; no ovf/udf. This holds regardless of en, and also in the same cycle as a would-be tick.
  2. tick & ~up_dn: tcnt<=tcnt+1 (mod 2^CNT_W); ovf<=1 when tcnt was 0xFF.
  3. tick & up_dn: tcnt<=tcnt-1 (mod 2^CNT_W); udf<=1 when tcnt was 0x00.
  4. Otherwise: hold.
- ovf and udf:
  - Each is high for exactly one cycle, on the same edge that tcnt wraps.
  - ovf and udf are never high together.
- Pause: en=0 freezes tcnt and clears psc. Re-enabling restarts a full prescaler period.
- Direction change: sampled per tick, with no latency beyond the next tick. Toggling up_dn while tcnt=0x00 with no tick in between produces no event.
- Width: all arithmetic is unsigned CNT_W bits; the wrap is natural modulo.
- Latency: tcnt reflects load one cycle after the load pulse, and reflects each tick on the same clock edge.

Test Plan:
- Reset → tcnt=0x00, ovf=udf=0. Assert rst_n low asynchronously mid-count at tcnt=0x37 → tcnt=0x00 immediately, without waiting for a clock edge.
- en=1, up_dn=0, cks=00 from 0x00 → tcnt=0xFF after 255 cycles. The next cycle gives tcnt=0x00 and ovf=1 for exactly 1 cycle.
- en=1, up_dn=1, cks=11, load tdr=0x02 → tcnt=0x02, then 0x01 after 8 cycles, then 0x00 after 16. At 24 cycles tcnt=0xFF and udf=1 for 1 cycle.
- cks=01 and cks=10, up from 0x10 → tcnt increments every 2 and every 4 cycles respectively. Check 0x14 at cycles 8 and 16 respectively.
- Counting up at 0xFF, pulse load with tdr=0x80 in the tick cycle → tcnt=0x80 and ovf stays 0.
- Pause: counting up at 0x20, drop en for 10 cycles → tcnt holds 0x20. Re-enable with cks=10 → first increment to 0x21 occurs 4 cycles later.

Source files
------------

// File: rtl/timer_cnt_core.sv
// Counting engine of the 8-bit timer: prescaler, load, up/down count, pause.
// Produces the live TCNT value and single-cycle overflow/underflow events
// that the register file turns into sticky status bits and the interrupt.
module timer_cnt_core #(
  parameter int CNT_W = 8,
  parameter int PSC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] tdr,
  input  logic             up_dn,
  input  logic [1:0]       cks,
  output logic [CNT_W-1:0] tcnt,
  output logic             tick,
  output logic             ovf,
  output logic             udf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [PSC_W-1:0] mask;

  // Division mask: tick whenever the low prescaler bits are all ones.
  always_comb begin
    mask = '0;
    case (cks)
      2'b00:   mask = PSC_W'(0);
      2'b01:   mask = PSC_W'(1);
      2'b10:   mask = PSC_W'(3);
      default: mask = PSC_W'(7);
    endcase
  end

  // A load cycle never counts; it restarts the prescaler period instead.
  assign tick = en & ~load & ((psc_q & mask) == mask);

  // Next-state for prescaler, counter and wrap events (load > tick > hold).
  always_comb begin
    psc_d  = (!en || load) ? '0 : psc_q + PSC_ONE;
    tcnt_d = tcnt_q;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    if (load) begin
      tcnt_d = tdr;
    end else if (tick && !up_dn) begin
      tcnt_d = tcnt_q + CNT_ONE;
      ovf_d  = (tcnt_q == CNT_MAX);
    end else if (tick && up_dn) begin
      tcnt_d = tcnt_q - CNT_ONE;
      udf_d  = (tcnt_q == '0);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q  <= '0;
      tcnt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      tcnt_q <= tcnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign tcnt = tcnt_q;
  assign ovf  = ovf_q;
  assign udf  = udf_q;

endmodule

// File: tb/tb_timer_cnt_core.sv
// Directed bench for timer_cnt_core: a table of single-cycle vectors plus
// hand-written multi-cycle sequences for the long counting corner cases.
module tb_timer_cnt_core;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] tdr;
  logic       up_dn;
  logic [1:0] cks;
  logic [7:0] tcnt;
  logic       tick;
  logic       ovf;
  logic       udf;

  int checks   = 0;
  int failures = 0;

  timer_cnt_core #(.CNT_W(8), .PSC_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .tdr   (tdr),
    .up_dn (up_dn),
    .cks   (cks),
    .tcnt  (tcnt),
    .tick  (tick),
    .ovf   (ovf),
    .udf   (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] tdr;
    logic       up_dn;
    logic [1:0] cks;
    logic       exp_tick;
    logic [7:0] exp_tcnt;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    check("ovf_udf_exclusive", {31'd0, ovf & udf}, 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; load = 1'b0; tdr = 8'h00; up_dn = 1'b0; cks = 2'b00;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] val, input logic en_v);
    en = en_v; load = 1'b1; tdr = val;
    step();
    load = 1'b0;
  endtask

  initial begin
    // en, load, tdr, up_dn, cks, exp_tick, exp_tcnt, exp_ovf, exp_udf
    vecs[0]  = '{1'b0, 1'b1, 8'h10, 1'b0, 2'b00, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 8'h12, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 2'b00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 8'h05, 1'b1, 2'b00, 1'b0, 8'h05, 1'b0, 1'b0};

    // Reset state
    do_reset();
    check("reset_tcnt", {24'd0, tcnt}, 32'h00);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_udf", {31'd0, udf}, 32'd0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 17; i++) begin
      en = vecs[i].en; load = vecs[i].load; tdr = vecs[i].tdr;
      up_dn = vecs[i].up_dn; cks = vecs[i].cks;
      #1;
      check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].exp_tick});
      step();
      check($sformatf("vec%0d_tcnt", i), {24'd0, tcnt}, {24'd0, vecs[i].exp_tcnt});
      check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
      check($sformatf("vec%0d_udf", i), {31'd0, udf}, {31'd0, vecs[i].exp_udf});
    end
    load = 1'b0;

    // Asynchronous reset mid-count at 0x37
    do_reset();
    do_load(8'h30, 1'b1);
    en = 1'b1; up_dn = 1'b0; cks = 2'b00;
    steps(7);
    check("pre_async_tcnt", {24'd0, tcnt}, 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tcnt", {24'd0, tcnt}, 32'h00);
    check("async_rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;

    // Full up-count wrap from 0x00
    do_reset();
    en = 1'b1; up_dn = 1'b0; cks = 2'b00;
    steps(255);
    check("full_up_ff", {24'd0, tcnt}, 32'hFF);
    check("full_up_ff_ovf", {31'd0, ovf}, 32'd0);
    step();
    check("wrap_tcnt", {24'd0, tcnt}, 32'h00);
    check("wrap_ovf", {31'd0, ovf}, 32'd1);
    step();
    check("wrap_ovf_1cyc", {31'd0, ovf}, 32'd0);
    check("wrap_next_tcnt", {24'd0, tcnt}, 32'h01);

    // Down-count /8 from 0x02 through underflow
    do_reset();
    up_dn = 1'b1; cks = 2'b11;
    do_load(8'h02, 1'b1);
    check("dn8_load", {24'd0, tcnt}, 32'h02);
    steps(7);
    check("dn8_hold7", {24'd0, tcnt}, 32'h02);
    step();
    check("dn8_c8", {24'd0, tcnt}, 32'h01);
    steps(8);
    check("dn8_c16", {24'd0, tcnt}, 32'h00);
    steps(7);
    check("dn8_c23_udf", {31'd0, udf}, 32'd0);
    step();
    check("dn8_c24", {24'd0, tcnt}, 32'hFF);
    check("dn8_c24_udf", {31'd0, udf}, 32'd1);
    step();
    check("dn8_udf_1cyc", {31'd0, udf}, 32'd0);

    // /2 and /4 up from 0x10
    do_reset();
    up_dn = 1'b0; cks = 2'b01;
    do_load(8'h10, 1'b1);
    steps(8);
    check("div2_c8", {24'd0, tcnt}, 32'h14);
    cks = 2'b10;
    do_load(8'h10, 1'b1);
    steps(15);
    check("div4_c15", {24'd0, tcnt}, 32'h13);
    step();
    check("div4_c16", {24'd0, tcnt}, 32'h14);

    // Load wins over a would-be tick at 0xFF
    do_reset();
    up_dn = 1'b0; cks = 2'b00;
    do_load(8'hFF, 1'b1);
    en = 1'b1;
    do_load(8'h80, 1'b1);
    check("load_vs_tick_tcnt", {24'd0, tcnt}, 32'h80);
    check("load_vs_tick_ovf", {31'd0, ovf}, 32'd0);

    // Pause holds, re-enable restarts a full /4 period
    do_reset();
    up_dn = 1'b0; cks = 2'b00;
    do_load(8'h20, 1'b0);
    en = 1'b0;
    steps(10);
    check("pause_hold", {24'd0, tcnt}, 32'h20);
    en = 1'b1; cks = 2'b10;
    steps(3);
    check("resume_c3", {24'd0, tcnt}, 32'h20);
    step();
    check("resume_c4", {24'd0, tcnt}, 32'h21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
